// File: rtl/i2c_slave_regfile.sv
// I2C target with a small byte-addressed register file.
// SCL/SDA are oversampled by clk; SDA is open-drain (drives 0 or Z only).
// Writes: device address (W), register pointer, then data bytes with auto-increment.
// Reads: device address (R), data bytes from the pointer with auto-increment on master ACK.
module i2c_slave_regfile #(
  parameter int REG_DEPTH = 8
) (
  input  logic       clk,
  input  logic       SCL,
  inout  wire        SDA,
  input  logic [6:0] addr,
  input  logic       rst
);

  localparam int PTR_W = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_DEV_ADDR  = 4'd1;
  localparam logic [3:0] S_DEV_ACK   = 4'd2;
  localparam logic [3:0] S_REG_ADDR  = 4'd3;
  localparam logic [3:0] S_REG_ACK   = 4'd4;
  localparam logic [3:0] S_WDATA     = 4'd5;
  localparam logic [3:0] S_WDATA_ACK = 4'd6;
  localparam logic [3:0] S_RDATA     = 4'd7;
  localparam logic [3:0] S_MACK      = 4'd8;

  logic [3:0]       r_state;
  logic             r_scl_q;
  logic             r_sda_q;
  logic             r_sda_low;
  logic             r_rw;
  logic [3:0]       r_bit_cnt;
  logic [7:0]       r_shift;
  logic [PTR_W-1:0] r_ptr;
  logic [7:0]       r_regs [REG_DEPTH];

  logic       w_sda_in;
  logic       w_scl_rise;
  logic       w_scl_fall;
  logic       w_start;
  logic       w_stop;
  logic       w_byte_done;
  logic [7:0] w_rd_byte;

  // Open-drain pad: pull low or release, never drive high.
  assign SDA = r_sda_low ? 1'b0 : 1'bz;

  assign w_sda_in    = SDA;
  assign w_scl_rise  = SCL & ~r_scl_q;
  assign w_scl_fall  = ~SCL & r_scl_q;
  assign w_start     = SCL & r_scl_q & ~w_sda_in & r_sda_q;
  assign w_stop      = SCL & r_scl_q & w_sda_in & ~r_sda_q;
  assign w_byte_done = (r_bit_cnt == 4'd8);
  assign w_rd_byte   = r_regs[r_ptr];

  // Bus sampling, protocol FSM, pointer and register file.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_scl_q   <= 1'b1;
      r_sda_q   <= 1'b1;
      r_sda_low <= 1'b0;
      r_rw      <= 1'b0;
      r_bit_cnt <= 4'd0;
      r_shift   <= 8'd0;
      r_ptr     <= '0;
      for (int i = 0; i < REG_DEPTH; i++) begin
        r_regs[i] <= 8'd0;
      end
    end else begin
      r_scl_q <= SCL;
      r_sda_q <= w_sda_in;
      if (w_start) begin
        // Any START (including repeated) restarts address reception; pointer kept.
        r_sda_low <= 1'b0;
        r_bit_cnt <= 4'd0;
        r_state   <= S_DEV_ADDR;
      end else if (w_stop) begin
        r_sda_low <= 1'b0;
        r_bit_cnt <= 4'd0;
        r_state   <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_state <= S_IDLE;
          end
          S_DEV_ADDR, S_REG_ADDR, S_WDATA: begin
            if (w_scl_rise && !w_byte_done) begin
              r_shift   <= {r_shift[6:0], w_sda_in};
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end else if (w_scl_fall && w_byte_done) begin
              r_bit_cnt <= 4'd0;
              if (r_state == S_DEV_ADDR) begin
                if (r_shift[7:1] == addr) begin
                  r_sda_low <= 1'b1;
                  r_rw      <= r_shift[0];
                  r_state   <= S_DEV_ACK;
                end else begin
                  r_state <= S_IDLE;
                end
              end else if (r_state == S_REG_ADDR) begin
                r_ptr     <= r_shift[PTR_W-1:0];
                r_sda_low <= 1'b1;
                r_state   <= S_REG_ACK;
              end else begin
                r_regs[r_ptr] <= r_shift;
                r_ptr         <= r_ptr + PTR_ONE;
                r_sda_low     <= 1'b1;
                r_state       <= S_WDATA_ACK;
              end
            end
          end
          S_DEV_ACK: begin
            if (w_scl_fall) begin
              if (r_rw) begin
                // First read bit goes out on the same fall that ends our ACK.
                r_sda_low <= ~w_rd_byte[7];
                r_bit_cnt <= 4'd1;
                r_state   <= S_RDATA;
              end else begin
                r_sda_low <= 1'b0;
                r_state   <= S_REG_ADDR;
              end
            end
          end
          S_REG_ACK, S_WDATA_ACK: begin
            if (w_scl_fall) begin
              r_sda_low <= 1'b0;
              r_state   <= S_WDATA;
            end
          end
          S_RDATA: begin
            if (w_scl_fall) begin
              if (w_byte_done) begin
                r_sda_low <= 1'b0;
                r_bit_cnt <= 4'd0;
                r_state   <= S_MACK;
              end else begin
                r_sda_low <= ~w_rd_byte[3'd7 - r_bit_cnt[2:0]];
                r_bit_cnt <= r_bit_cnt + 4'd1;
              end
            end
          end
          S_MACK: begin
            // Bit count 1 here marks "master ACK seen, pointer already advanced".
            if (w_scl_rise) begin
              if (!w_sda_in) begin
                r_ptr     <= r_ptr + PTR_ONE;
                r_bit_cnt <= 4'd1;
              end else begin
                r_state <= S_IDLE;
              end
            end else if (w_scl_fall && (r_bit_cnt == 4'd1)) begin
              r_sda_low <= ~w_rd_byte[7];
              r_state   <= S_RDATA;
            end
          end
          default: begin
            r_sda_low <= 1'b0;
            r_bit_cnt <= 4'd0;
            r_state   <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Directed bench for i2c_slave_regfile: a bit-banging master, a transaction-level
// model of register contents and pointer, and one compare process.
module tb_i2c_slave_regfile;

  localparam logic [6:0] DEV = 7'h11;

  logic       clk = 1'b0;
  logic       rst;
  logic       m_scl;
  logic       m_sda;
  logic [6:0] dev_addr = DEV;
  tri1        sda_bus;

  assign sda_bus = m_sda ? 1'bz : 1'b0;

  i2c_slave_regfile #(.REG_DEPTH(8)) dut (
    .clk  (clk),
    .SCL  (m_scl),
    .SDA  (sda_bus),
    .addr (dev_addr),
    .rst  (rst)
  );

  always #5 clk = ~clk;

  // model state
  logic [7:0] mdl_regs [8];
  logic [2:0] mdl_ptr;
  logic [7:0] rbuf [16];
  int         rcnt;

  // compare requests
  int         total = 0;
  int         bad   = 0;
  logic       chk_en = 1'b0;
  logic       exp_sda;
  string      chk_name;
  logic       lit_en = 1'b0;
  logic [7:0] lit_got;
  logic [7:0] lit_exp;
  string      lit_name;

  // Single compare process, sampling on the inactive clock edge.
  always @(negedge clk) begin
    if (chk_en) begin
      total++;
      if (sda_bus !== exp_sda) begin
        bad++;
        $display("FAIL sda_%s: got %b want %b at %0t", chk_name, sda_bus, exp_sda, $time);
      end
    end
    if (lit_en) begin
      total++;
      if (lit_got !== lit_exp) begin
        bad++;
        $display("FAIL %s: got %02h want %02h", lit_name, lit_got, lit_exp);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_lit(input string name, input logic [7:0] got, input logic [7:0] exp);
    lit_name = name;
    lit_got  = got;
    lit_exp  = exp;
    lit_en   = 1'b1;
    tick(1);
    lit_en   = 1'b0;
  endtask

  task automatic clk_bit(input logic drv, input logic exp, input string name, output logic got);
    m_sda = drv;
    tick(2);
    m_scl = 1'b1;
    tick(1);
    exp_sda  = exp;
    chk_name = name;
    chk_en   = 1'b1;
    tick(2);
    chk_en = 1'b0;
    got    = sda_bus;
    tick(1);
    m_scl = 1'b0;
    tick(1);
  endtask

  task automatic m_start();
    m_sda = 1'b1;
    tick(2);
    m_scl = 1'b1;
    tick(3);
    m_sda = 1'b0;
    tick(3);
    m_scl = 1'b0;
    tick(1);
  endtask

  task automatic m_stop();
    m_sda = 1'b0;
    tick(2);
    m_scl = 1'b1;
    tick(3);
    m_sda = 1'b1;
    tick(3);
  endtask

  task automatic m_send_byte(input logic [7:0] b, input logic exp_ack);
    logic g;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(b[i], b[i], "wbit", g);
    end
    clk_bit(1'b1, ~exp_ack, "ack", g);
  endtask

  task automatic m_recv_byte(input logic [7:0] exp, input logic ack, output logic [7:0] got);
    logic g;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, exp[i], "rbit", g);
      got[i] = g;
    end
    clk_bit(~ack, ~ack, "mack", g);
  endtask

  task automatic addr_phase(input logic [7:0] devbyte);
    m_send_byte(devbyte, devbyte[7:1] == DEV);
  endtask

  // START, write pointer, then n data bytes base, base+step, ...
  task automatic wr_txn(input logic [7:0] ra, input int n, input logic [7:0] base, input logic [7:0] step);
    logic [7:0] d;
    m_start();
    addr_phase({DEV, 1'b0});
    m_send_byte(ra, 1'b1);
    mdl_ptr = ra[2:0];
    d = base;
    for (int i = 0; i < n; i++) begin
      m_send_byte(d, 1'b1);
      mdl_regs[mdl_ptr] = d;
      mdl_ptr = mdl_ptr + 3'd1;
      d = d + step;
    end
  endtask

  // Set pointer, repeated START, read n bytes (ACK all but last), STOP.
  task automatic rd_txn(input logic [7:0] ra, input int n);
    logic [7:0] got;
    m_start();
    addr_phase({DEV, 1'b0});
    m_send_byte(ra, 1'b1);
    mdl_ptr = ra[2:0];
    m_start();
    addr_phase({DEV, 1'b1});
    for (int i = 0; i < n; i++) begin
      m_recv_byte(mdl_regs[mdl_ptr], i < n - 1, got);
      rbuf[rcnt[3:0]] = got;
      rcnt++;
      if (i < n - 1) mdl_ptr = mdl_ptr + 3'd1;
    end
    m_stop();
  endtask

  initial begin
    logic g;
    rst   = 1'b1;
    m_scl = 1'b1;
    m_sda = 1'b1;
    rcnt  = 0;
    for (int i = 0; i < 8; i++) mdl_regs[i] = 8'h00;
    mdl_ptr = 3'd0;
    tick(3);
    rst = 1'b0;
    tick(2);
    check_lit("reset_sda_released", {7'd0, sda_bus}, 8'h01);

    // write 0x00..0x77 from reg 0, twice
    wr_txn(8'h00, 8, 8'h00, 8'h11);
    m_stop();
    wr_txn(8'h00, 8, 8'h00, 8'h11);
    m_stop();

    // read reg 3, master NACK
    rcnt = 0;
    rd_txn(8'h03, 1);
    check_lit("read_reg3", rbuf[0], 8'h33);

    // read with ACK: 0x33 then 0x44
    rd_txn(8'h03, 2);
    check_lit("read_inc", rbuf[2], 8'h44);

    // read across wrap: 0x66 0x77 0x00 0x11
    rcnt = 4;
    rd_txn(8'h06, 4);
    check_lit("read_wrap", rbuf[6], 8'h00);
    check_lit("read_after_wrap", rbuf[7], 8'h11);

    // wrong device address: no ACK, writes ignored
    m_start();
    addr_phase(8'h24);
    m_send_byte(8'h05, 1'b0);
    m_send_byte(8'h99, 1'b0);
    m_stop();
    rcnt = 8;
    rd_txn(8'h05, 1);
    check_lit("ignored_write", rbuf[8], 8'h55);

    // write 0xAA to reg 5, then STOP partway through the next byte
    wr_txn(8'h05, 1, 8'hAA, 8'h00);
    clk_bit(1'b1, 1'b1, "partial", g);
    clk_bit(1'b0, 1'b0, "partial", g);
    clk_bit(1'b1, 1'b1, "partial", g);
    m_stop();
    rcnt = 9;
    rd_txn(8'h05, 2);
    check_lit("reg5_written", rbuf[9], 8'hAA);
    check_lit("reg6_kept", rbuf[10], 8'h66);

    // reset while the slave drives bit 7 (0) of reg 1 = 0x11
    m_start();
    addr_phase({DEV, 1'b0});
    m_send_byte(8'h01, 1'b1);
    m_start();
    addr_phase({DEV, 1'b1});
    tick(2);
    check_lit("read_drives_low", {7'd0, sda_bus}, 8'h00);
    rst = 1'b1;
    tick(1);
    check_lit("rst_releases_sda", {7'd0, sda_bus}, 8'h01);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) mdl_regs[i] = 8'h00;
    mdl_ptr = 3'd0;
    m_sda = 1'b1;
    m_scl = 1'b1;
    tick(4);
    rcnt = 11;
    rd_txn(8'h00, 2);
    check_lit("rst_cleared_reg0", rbuf[11], 8'h00);
    check_lit("rst_cleared_reg1", rbuf[12], 8'h00);

    tick(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
